stream_scaler_pipe: RTL and testbench
=====================================

Name: stream_scaler_pipe

Overview:
Parametrised 3-stage streaming scaler for the DMA path. It sits between the DMA-read Avalon-ST source and the DMA-write Avalon-ST sink and is controlled over an Avalon-MM CSR slave. Each beat is computed as out = (in × coeff × RECIP) >> SHIFT, with optional byte-swap at entry and exit and a per-beat bypass mode. Control bits are captured per beat, so mode changes never corrupt beats already in flight.

Parameters:
DATA_W, 32, stream data width; a multiple of 8, 8..64.
COEF_W, 32, coefficient register width.
RECIP, 5243, fixed reciprocal multiplier.
RECIP_W, 13, bit width of RECIP.
SHIFT, 21, right shift applied after the reciprocal multiply. Default pair divides by ~400.
VERSION, 32'h0000_0200, value returned by the version CSR.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  3  CSR word address
avs_write  in  1  CSR write strobe
avs_writedata  in  32  CSR write data
avs_read  in  1  CSR read strobe
avs_readdata  out  32  CSR read data, registered
avs_readdatavalid  out  1  high exactly one cycle after avs_read
asi_valid  in  1  sink valid
asi_data  in  DATA_W  sink data
asi_ready  out  1  sink ready
aso_valid  out  1  source valid
aso_data  out  DATA_W  source data
aso_ready  in  1  source ready

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. Reset values:
  - all pipe_valid bits 0, so aso_valid=0 and asi_ready=1;
  - aso_data=0, avs_readdata=0, avs_readdatavalid=0;
  - coeff=1, ctrl.bypass=0, ctrl.swap=1, all counters 0.
- Reset asserted mid-stream discards in-flight beats without emitting them.
- CSR map:
  - 0: coeff (RW, low COEF_W bits).
  - 1: ctrl (RW). bit0 bypass; bit1 swap; bit2 clr (write-1 self-clearing, reads 0).
  - 2: in_count (RO).
  - 3: out_count (RO).
  - 4: last_in (RO). Last accepted beat after the entry swap, zero-extended to 32 bits.
  - 5: stall_count (RO). Counts cycles with aso_valid=1 and aso_ready=0.
  - 6: VERSION (RO).
  - 7: reads 0; writes are ignored.
- CSR read/write timing:
  - Read latency is exactly 1 cycle; avs_readdatavalid=1 in the cycle after avs_read.
  - A write and a read to the same address in the same cycle return the old value.
- Handshake:
  - A beat transfers on valid&&ready. Stage k advances when pipe_ready[k] = !pipe_valid[k] || pipe_ready[k+1], with pipe_ready[3]=aso_ready and asi_ready=pipe_ready[0].
  - Full throughput is one beat per cycle. Latency is 3 cycles from acceptance to aso_valid.
  - aso_data and aso_valid hold stable while aso_ready=0.
- Stage 0 (accept):
  - Latch the beat's bypass and swap bits from ctrl.
  - Data is byte-reversed if swap=1; this value also updates last_in.
  - in_count increments.
- Stage 1:
  - bypass=1: pass the data through.
  - Otherwise: prod = data × coeff, full DATA_W+COEF_W bits, unsigned.
- Stage 2:
  - bypass=1: pass the data through.
  - Otherwise: res = (prod × RECIP) >> SHIFT, computed at DATA_W+COEF_W+RECIP_W bits, then reduced to DATA_W bits (see Optional Feature).
  - Byte-reverse again if the beat's swap bit is 1.
  - out_count increments when the stage loads a valid beat.
- Counters:
  - All counters are 32-bit and wrap modulo 2^32.
  - clr zeroes in_count, out_count and stall_count; clr wins over a same-cycle increment.
- Writes to ctrl or coeff affect only beats accepted in later cycles. Exception: coeff is read live in stage 1; software changes coeff only when idle.

Optional Feature:
Macro STREAM_SCALER_SAT_EN.
- Defined: if res ≥ 2^DATA_W, the output is all-ones, and a sticky ctrl bit3 (sat_flag, RO, cleared by clr) sets.
- Undefined: res is truncated to its low DATA_W bits, and ctrl bit3 reads 0.

Test Plan:
- Reset, then read addr 6 -> readdatavalid one cycle later with 0x00000200. Read addr 1 -> 0x2.
- coeff=400, swap=1, send asi_data=0xE8030000 -> aso_data=0xE8030000 three cycles later; in_count=out_count=1; last_in=0x000003E8.
- Bypass with swap=0, 8 back-to-back beats 0..7, aso_ready=1 -> identical beats out, one per cycle, first at cycle 3.
- Hold aso_ready=0 for 10 cycles with 5 beats offered -> asi_ready drops after 3 accepted; stall_count=10. Release -> all 5 beats out in order, none lost or duplicated.
- Toggle bypass between beat 1 and beat 2 while beat 1 is in flight -> beat 1 is scaled, beat 2 is bypassed.
- swap=0, coeff=0xFFFFFFFF, data=0xFFFFFFFF -> with STREAM_SCALER_SAT_EN, out=0xFFFFFFFF and ctrl bit3=1; without it, out equals the low 32 bits of the exact result. Then clr -> counters and flag read 0.

Source files
------------

// File: rtl/stream_scaler_pipe.sv
// Three-stage Avalon-ST scaler: out = (in * coeff * RECIP) >> SHIFT, with an Avalon-MM CSR slave.
// Define STREAM_SCALER_SAT_EN to saturate overflowing results and expose a sticky ctrl bit3.
module stream_scaler_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COEF_W  = 32,
  parameter int unsigned RECIP   = 5243,
  parameter int unsigned RECIP_W = 13,
  parameter int unsigned SHIFT   = 21,
  parameter logic [31:0] VERSION = 32'h0000_0200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              asi_valid,
  input  logic [DATA_W-1:0] asi_data,
  output logic              asi_ready,
  output logic              aso_valid,
  output logic [DATA_W-1:0] aso_data,
  input  logic              aso_ready
);
  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam int unsigned ResW  = ProdW + RECIP_W;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 8; i++) r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
    return r;
  endfunction

  logic [COEF_W-1:0] coeff_q;
  logic              bypass_q, swap_q;
  logic [31:0]       in_count_q, out_count_q, stall_count_q, last_in_q;
  logic [31:0]       avs_readdata_q, rd_mux;
  logic              avs_readdatavalid_q;
  logic              sat_flag;

  logic [2:0]        valid_q;
  logic [DATA_W-1:0] s0_data_q, s2_data_q;
  logic              s0_bypass_q, s0_swap_q, s1_bypass_q, s1_swap_q;
  logic [ProdW-1:0]  s1_prod_q;

  logic rdy0, rdy1, rdy2, acc, ld1, ld2;
  logic wr_coeff, wr_ctrl, clr;

  assign rdy2 = !valid_q[2] || aso_ready;
  assign rdy1 = !valid_q[1] || rdy2;
  assign rdy0 = !valid_q[0] || rdy1;
  assign acc  = asi_valid && rdy0;
  assign ld1  = valid_q[0] && rdy1;
  assign ld2  = valid_q[1] && rdy2;

  assign asi_ready         = rdy0;
  assign aso_valid         = valid_q[2];
  assign aso_data          = s2_data_q;
  assign avs_readdata      = avs_readdata_q;
  assign avs_readdatavalid = avs_readdatavalid_q;

  assign wr_coeff = avs_write && (avs_address == 3'd0);
  assign wr_ctrl  = avs_write && (avs_address == 3'd1);
  assign clr      = wr_ctrl && avs_writedata[2];

  logic [DATA_W-1:0] s0_in, s2_scaled, s2_val, s2_out;
  logic [ProdW-1:0]  s1_next;

  assign s0_in   = swap_q ? byte_rev(asi_data) : asi_data;
  // coeff is sampled live here; software only changes it while the pipe is idle
  assign s1_next = s0_bypass_q ? ProdW'(s0_data_q) : ProdW'(s0_data_q) * ProdW'(coeff_q);

`ifdef STREAM_SCALER_SAT_EN
  logic [ResW-1:0] res_full;
  logic            s2_sat;
  logic            sat_flag_q;

  assign res_full  = (ResW'(s1_prod_q) * ResW'(RECIP)) >> SHIFT;
  assign s2_sat    = |res_full[ResW-1:DATA_W];
  assign s2_scaled = s2_sat ? '1 : res_full[DATA_W-1:0];
  assign sat_flag  = sat_flag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag_q <= 1'b0;
    end else if (clr) begin
      sat_flag_q <= 1'b0;
    end else if (ld2 && !s1_bypass_q && s2_sat) begin
      sat_flag_q <= 1'b1;
    end
  end
`else
  assign s2_scaled = DATA_W'((ResW'(s1_prod_q) * ResW'(RECIP)) >> SHIFT);
  assign sat_flag  = 1'b0;
`endif

  assign s2_val = s1_bypass_q ? s1_prod_q[DATA_W-1:0] : s2_scaled;
  assign s2_out = s1_swap_q ? byte_rev(s2_val) : s2_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      s0_data_q   <= '0;
      s0_bypass_q <= 1'b0;
      s0_swap_q   <= 1'b0;
      s1_prod_q   <= '0;
      s1_bypass_q <= 1'b0;
      s1_swap_q   <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      if (rdy0) valid_q[0] <= asi_valid;
      if (rdy1) valid_q[1] <= valid_q[0];
      if (rdy2) valid_q[2] <= valid_q[1];
      if (acc) begin
        s0_data_q   <= s0_in;
        s0_bypass_q <= bypass_q;
        s0_swap_q   <= swap_q;
      end
      if (ld1) begin
        s1_prod_q   <= s1_next;
        s1_bypass_q <= s0_bypass_q;
        s1_swap_q   <= s0_swap_q;
      end
      if (ld2) s2_data_q <= s2_out;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux = 32'(coeff_q);
      3'd1:    rd_mux = {28'd0, sat_flag, 1'b0, swap_q, bypass_q};
      3'd2:    rd_mux = in_count_q;
      3'd3:    rd_mux = out_count_q;
      3'd4:    rd_mux = last_in_q;
      3'd5:    rd_mux = stall_count_q;
      3'd6:    rd_mux = VERSION;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coeff_q             <= COEF_W'(1);
      bypass_q            <= 1'b0;
      swap_q              <= 1'b1;
      in_count_q          <= '0;
      out_count_q         <= '0;
      stall_count_q       <= '0;
      last_in_q           <= '0;
      avs_readdata_q      <= '0;
      avs_readdatavalid_q <= 1'b0;
    end else begin
      avs_readdatavalid_q <= avs_read;
      if (avs_read) avs_readdata_q <= rd_mux;
      if (wr_coeff) coeff_q <= COEF_W'(avs_writedata);
      if (wr_ctrl) begin
        bypass_q <= avs_writedata[0];
        swap_q   <= avs_writedata[1];
      end
      if (acc) last_in_q <= 32'(s0_in);
      if (clr)      in_count_q <= '0;
      else if (acc) in_count_q <= in_count_q + 32'd1;
      if (clr)      out_count_q <= '0;
      else if (ld2) out_count_q <= out_count_q + 32'd1;
      if (clr)                         stall_count_q <= '0;
      else if (aso_valid && !aso_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_stream_scaler_pipe.sv
// Self-checking bench for stream_scaler_pipe: directed steps plus randomized traffic against a
// queue-based arithmetic reference model.
module tb_stream_scaler_pipe;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_readdatavalid;
  logic        asi_valid, asi_ready, aso_valid, aso_ready;
  logic [31:0] asi_data, aso_data;

  stream_scaler_pipe dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .asi_valid         (asi_valid),
    .asi_data          (asi_data),
    .asi_ready         (asi_ready),
    .aso_valid         (aso_valid),
    .aso_data          (aso_data),
    .aso_ready         (aso_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [31:0] tx_q[$], exp_q[$], got_q[$];
  int          acc_cyc_q[$], out_cyc_q[$];
  logic [31:0] mdl_coeff = 32'd1;
  logic        mdl_bypass = 1'b0, mdl_swap = 1'b1, mdl_sat = 1'b0;
  int unsigned mdl_in = 0;
  logic [31:0] mdl_last = '0;
  logic [31:0] am_d;
  logic        am_s;

  function automatic logic [31:0] rev32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Reference: exact product at 128 bits, then reduce to 32 bits
  function automatic logic [31:0] model_beat(input logic [31:0] d, input logic [31:0] c,
                                             input logic byp, input logic swp, output logic sat);
    logic [31:0]  x, y;
    logic [127:0] wide;
    sat = 1'b0;
    x = swp ? rev32(d) : d;
    if (byp) begin
      y = x;
    end else begin
      wide = ({96'd0, x} * {96'd0, c} * 128'd5243) >> 21;
      y = wide[31:0];
      if (wide > 128'hFFFF_FFFF) begin
        sat = 1'b1;
`ifdef STREAM_SCALER_SAT_EN
        y = 32'hFFFF_FFFF;
`endif
      end
    end
    return swp ? rev32(y) : y;
  endfunction

  always @(negedge clk) begin
    if (reset_n && asi_valid && asi_ready && tx_q.size() > 0) begin
      am_d = tx_q.pop_front();
      exp_q.push_back(model_beat(am_d, mdl_coeff, mdl_bypass, mdl_swap, am_s));
`ifdef STREAM_SCALER_SAT_EN
      if (am_s) mdl_sat = 1'b1;
`endif
      mdl_last = mdl_swap ? rev32(am_d) : am_d;
      mdl_in++;
      acc_cyc_q.push_back(cyc);
    end
    if (reset_n && aso_valid && aso_ready) begin
      got_q.push_back(aso_data);
      out_cyc_q.push_back(cyc);
    end
  end

  initial begin
    asi_valid = 1'b0;
    asi_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_q.size() > 0) begin
        asi_valid = 1'b1;
        asi_data  = tx_q[0];
      end else begin
        asi_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    step();
    avs_write = 1'b0;
    if (a == 3'd0) mdl_coeff = d;
    if (a == 3'd1) begin
      mdl_bypass = d[0];
      mdl_swap = d[1];
      if (d[2]) begin
        mdl_in = 0;
        mdl_sat = 1'b0;
      end
    end
  endtask

  task automatic csr_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    chk({tag, "_rdv"}, avs_readdatavalid, 1);
    chk(tag, avs_readdata, exp);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((tx_q.size() > 0 || got_q.size() < exp_q.size()) && n < 500) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({tag, "_timeout"}, (n >= 500), 0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_lat(input string tag);
    while (acc_cyc_q.size() > 0 && out_cyc_q.size() > 0)
      chk(tag, 64'(out_cyc_q.pop_front() - acc_cyc_q.pop_front()), 64'd3);
    acc_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  initial begin
    int n;
    avs_address = '0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_read = 1'b0;
    aso_ready = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state and basic CSR reads
    chk("rst_aso_valid", aso_valid, 0);
    chk("rst_asi_ready", asi_ready, 1);
    chk("rst_aso_data", aso_data, 0);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_rdv", avs_readdatavalid, 0);
    csr_chk(3'd6, 32'h0000_0200, "version");
    step();
    chk("rdv_one_cycle", avs_readdatavalid, 0);
    csr_chk(3'd1, 32'h2, "ctrl_rst");
    csr_chk(3'd0, 32'h1, "coeff_rst");
    csr_chk(3'd2, 32'h0, "in_count_rst");
    csr_chk(3'd7, 32'h0, "addr7");

    // same-cycle write and read of coeff returns the old value
    avs_address = 3'd0;
    avs_writedata = 32'd400;
    avs_write = 1'b1;
    avs_read = 1'b1;
    step();
    avs_write = 1'b0;
    avs_read = 1'b0;
    mdl_coeff = 32'd400;
    chk("wr_rd_old", avs_readdata, 1);
    csr_chk(3'd0, 32'd400, "coeff_new");

    // scaled beat with swap
    acc_cyc_q.delete();
    out_cyc_q.delete();
    tx_q.push_back(32'hE803_0000);
    drain("scale");
    chk("scale_const", got_q[0], 32'hE803_0000);
    check_stream("scale");
    check_lat("scale_lat");
    csr_chk(3'd2, 32'd1, "in_count1");
    csr_chk(3'd3, 32'd1, "out_count1");
    csr_chk(3'd4, 32'h0000_03E8, "last_in");

    // bypass, no swap, back-to-back
    csr_write(3'd1, 32'h1);
    for (int i = 0; i < 8; i++) tx_q.push_back(32'(i));
    drain("bypass");
    for (int i = 1; i < out_cyc_q.size(); i++)
      chk("bp_rate", 64'(out_cyc_q[i] - out_cyc_q[i-1]), 64'd1);
    check_stream("bypass");
    check_lat("bp_lat");
    csr_chk(3'd3, 32'(mdl_in), "out_count9");

    // backpressure: 3 accepted, then 10 stall cycles
    aso_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx_q.push_back(32'(100 + i));
    n = 0;
    while (aso_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("stall_fill_timeout", (n >= 20), 0);
    repeat (10) step();
    chk("stall_asi_ready", asi_ready, 0);
    chk("stall_accepted", tx_q.size(), 2);
    chk("stall_hold_valid", aso_valid, 1);
    chk("stall_hold_data", aso_data, exp_q[0]);
    aso_ready = 1'b1;
    drain("stall");
    check_stream("stall");
    csr_chk(3'd5, 32'd10, "stall_count");
    csr_chk(3'd2, 32'(mdl_in), "in_count_stall");

    // mode change while a beat is in flight
    csr_write(3'd1, 32'h0);
    csr_write(3'd0, 32'd1200);
    tx_q.push_back(32'd20000);
    n = 0;
    while (tx_q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    csr_write(3'd1, 32'h1);
    tx_q.push_back(32'd20000);
    drain("toggle");
    chk("toggle_scaled", got_q[0], 32'd60001);
    chk("toggle_bypass", got_q[1], 32'd20000);
    check_stream("toggle");

    // randomized traffic with backpressure and live ctrl changes
    for (int r = 0; r < 4; r++) begin
      csr_write(3'd0, (r % 2 == 1) ? $urandom : $urandom_range(1, 3000));
      for (int i = 0; i < 16; i++) tx_q.push_back($urandom);
      for (int c = 0; c < 60; c++) begin
        aso_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) csr_write(3'd1, 32'($urandom_range(0, 3)));
        else step();
      end
      aso_ready = 1'b1;
      drain("rand");
      check_stream("rand");
    end
    csr_chk(3'd2, 32'(mdl_in), "in_count_rand");
    csr_chk(3'd3, 32'(mdl_in), "out_count_rand");
    csr_chk(3'd4, mdl_last, "last_in_rand");

    // overflow case, then clear
    csr_write(3'd1, 32'h0);
    csr_write(3'd0, 32'hFFFF_FFFF);
    tx_q.push_back(32'hFFFF_FFFF);
    drain("ovf");
    check_stream("ovf");
    csr_chk(3'd1, {28'd0, mdl_sat, 3'b000}, "ctrl_sat");
    csr_write(3'd1, 32'h4);
    csr_chk(3'd2, 32'd0, "clr_in");
    csr_chk(3'd3, 32'd0, "clr_out");
    csr_chk(3'd5, 32'd0, "clr_stall");
    csr_chk(3'd1, 32'd0, "clr_ctrl");

    // reset mid-stream drops in-flight beats
    csr_write(3'd1, 32'h1);
    for (int i = 0; i < 3; i++) tx_q.push_back(32'(50 + i));
    repeat (2) step();
    reset_n = 1'b0;
    tx_q.delete();
    step();
    chk("midrst_valid", aso_valid, 0);
    reset_n = 1'b1;
    exp_q.delete();
    mdl_in = 0;
    repeat (6) step();
    chk("midrst_no_out", got_q.size(), 0);
    csr_chk(3'd2, 32'd0, "midrst_in_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
